router_egress_arbiter: RTL and testbench

- Drains the three router output FIFOs (channels 0/1/2) onto one shared egress byte stream.
- Arbitrates round-robin, one whole packet per grant, with valid/ready backpressure on the egress side.
- Owns the per-channel soft reset. If a granted packet stalls on egress for TIMEOUT cycles, the packet is aborted and that channel's FIFO is flushed.

---
 rtl/router_egress_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_router_egress_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_egress_arbiter.sv
// Round-robin egress arbiter: one packet per grant from three FIFOs, first byte out 2 cycles after the header read.
// Holds on !out_ready, aborts and flushes the channel after TIMEOUT stalled cycles; PARITY_CHECK_EN adds the parity check.
module router_egress_arbiter #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 6,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic [DATA_W-1:0] data_out_0,
  input  logic [DATA_W-1:0] data_out_1,
  input  logic [DATA_W-1:0] data_out_2,
  output logic              read_enb_0,
  output logic              read_enb_1,
  output logic              read_enb_2,
  output logic              soft_reset_0,
  output logic              soft_reset_1,
  output logic              soft_reset_2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        grant_chan,
  output logic              busy,
  output logic              parity_err
);

  localparam int               SW         = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]    STALL_LAST = SW'(TIMEOUT - 1);
  localparam logic [SW-1:0]    STALL_ONE  = SW'(1);
  localparam logic [LEN_W:0]   REM_ONE    = (LEN_W + 1)'(1);

  typedef enum logic [2:0] {IDLE, HEADER, STREAM, DONE, ABORT} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
`ifdef PARITY_CHECK_EN
    logic              perr;
`endif
  } ent_t;

  state_t            state, state_nx;
  logic [1:0]        rr_ptr, grant_q, pick, pick_c1, pick_c2;
  logic              pick_vld;
  logic [2:0]        empty_v;
  logic              empty_sel;
  logic [DATA_W-1:0] data_sel;
  logic [LEN_W:0]    remaining, eff_rem;
  logic              rd_pend, rd_last, hdr_inflight;
  logic              rd_issue, can_read, pop, stream_end, timeout_hit;
  logic [1:0]        occ, slots_used;
  ent_t              ent0, ent1, push_ent;
  logic [SW-1:0]     stall_cnt;

  function automatic logic [1:0] inc3(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  assign empty_v = {fifo_empty_2, fifo_empty_1, fifo_empty_0};

  always_comb begin
    empty_sel = 1'b1;
    data_sel  = '0;
    case (grant_q)
      2'd0:    begin empty_sel = fifo_empty_0; data_sel = data_out_0; end
      2'd1:    begin empty_sel = fifo_empty_1; data_sel = data_out_1; end
      2'd2:    begin empty_sel = fifo_empty_2; data_sel = data_out_2; end
      default: ;
    endcase
  end

  always_comb begin
    pick_c1  = inc3(rr_ptr);
    pick_c2  = inc3(pick_c1);
    pick_vld = 1'b0;
    pick     = rr_ptr;
    if (!empty_v[rr_ptr]) begin
      pick_vld = 1'b1;
    end else if (!empty_v[pick_c1]) begin
      pick_vld = 1'b1;
      pick     = pick_c1;
    end else if (!empty_v[pick_c2]) begin
      pick_vld = 1'b1;
      pick     = pick_c2;
    end
  end

  assign out_valid   = (occ != 2'd0);
  assign pop         = out_valid & out_ready;
  assign timeout_hit = out_valid && !out_ready && (stall_cnt == STALL_LAST);

  // The header read lands in the first STREAM cycle, so its length is used straight off the FIFO bus.
  assign eff_rem = hdr_inflight ? ({1'b0, data_sel[2 +: LEN_W]} + REM_ONE) : remaining;

  // Slots counted after this cycle's pop: keeps the buffer at or under 2 entries without a bubble.
  assign slots_used = occ - {1'b0, pop} + {1'b0, rd_pend};
  assign can_read   = (state == STREAM) && (eff_rem != '0) && !empty_sel &&
                      (slots_used < 2'd2) && !timeout_hit;
  assign rd_issue   = ((state == HEADER) && !empty_sel) || can_read;
  assign stream_end = (state == STREAM) && (eff_rem == '0) && !rd_pend && (occ == 2'd1) && pop;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = HEADER;
      HEADER:  if (!empty_sel) state_nx = STREAM;
      STREAM:  if (stream_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (timeout_hit && (state inside {HEADER, STREAM, DONE})) state_nx = ABORT;
  end

  always_comb begin
    read_enb_0   = rd_issue && (grant_q == 2'd0);
    read_enb_1   = rd_issue && (grant_q == 2'd1);
    read_enb_2   = rd_issue && (grant_q == 2'd2);
    soft_reset_0 = (state == ABORT) && (grant_q == 2'd0);
    soft_reset_1 = (state == ABORT) && (grant_q == 2'd1);
    soft_reset_2 = (state == ABORT) && (grant_q == 2'd2);
    busy         = (state != IDLE);
  end

  assign grant_chan = grant_q;
  assign out_data   = out_valid ? ent0.data : '0;
  assign out_last   = out_valid & ent0.last;

`ifdef PARITY_CHECK_EN
  logic [DATA_W-1:0] par_acc;

  always_ff @(posedge clock) begin
    if (reset || state == IDLE)  par_acc <= '0;
    else if (rd_pend && !rd_last) par_acc <= par_acc ^ data_sel;
  end

  always_comb begin
    push_ent      = '0;
    push_ent.data = data_sel;
    push_ent.last = rd_last;
    push_ent.perr = rd_last && (par_acc != data_sel);
  end

  assign parity_err = pop & ent0.perr;
`else
  always_comb begin
    push_ent      = '0;
    push_ent.data = data_sel;
    push_ent.last = rd_last;
  end

  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr       <= 2'd0;
      grant_q      <= 2'b11;
      remaining    <= '0;
      rd_pend      <= 1'b0;
      rd_last      <= 1'b0;
      hdr_inflight <= 1'b0;
      occ          <= 2'd0;
      ent0         <= '0;
      ent1         <= '0;
      stall_cnt    <= '0;
    end else begin
      rd_pend      <= rd_issue;
      rd_last      <= can_read && (eff_rem == REM_ONE);
      hdr_inflight <= (state == HEADER) && rd_issue;
      if (state == STREAM) remaining <= can_read ? eff_rem - REM_ONE : eff_rem;

      case (state)
        IDLE:        if (pick_vld) grant_q <= pick;
        DONE, ABORT: begin
          rr_ptr  <= inc3(grant_q);
          grant_q <= 2'b11;
        end
        default: ;
      endcase

      if (timeout_hit || pop || state == IDLE) stall_cnt <= '0;
      else if (out_valid && !out_ready)        stall_cnt <= stall_cnt + STALL_ONE;

      if (timeout_hit) begin
        occ <= 2'd0;
      end else begin
        case ({rd_pend, pop})
          2'b10: begin
            if (occ == 2'd0) ent0 <= push_ent;
            else             ent1 <= push_ent;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            ent0 <= ent1;
            occ  <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd1) begin
              ent0 <= push_ent;
            end else begin
              ent0 <= ent1;
              ent1 <= push_ent;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Directed bench for router_egress_arbiter: behavioural FIFOs feed the DUT, a negedge monitor logs egress traffic.
module tb_router_egress_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       out_ready = 1'b1;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic [7:0] out_data;
  logic       out_valid, out_last, busy, parity_err;
  logic [1:0] grant_chan;

  always #5 clock = ~clock;

  router_egress_arbiter #(.DATA_W(8), .LEN_W(6), .TIMEOUT(30)) dut (
    .clock(clock), .reset(reset),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .grant_chan(grant_chan), .busy(busy), .parity_err(parity_err)
  );

  logic [7:0] mem [3][256];
  int         wp [3];
  int         rp [3];
  logic [7:0] dout [3];
  logic [2:0] re, sr, emp;
  int         cyc;

  assign re = {read_enb_2, read_enb_1, read_enb_0};
  assign sr = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign emp[0] = (wp[0] == rp[0]);
  assign emp[1] = (wp[1] == rp[1]);
  assign emp[2] = (wp[2] == rp[2]);
  assign fifo_empty_0 = emp[0];
  assign fifo_empty_1 = emp[1];
  assign fifo_empty_2 = emp[2];
  assign data_out_0 = dout[0];
  assign data_out_1 = dout[1];
  assign data_out_2 = dout[2];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 3; c++) begin
      if (sr[c]) rp[c] <= wp[c];
      else if (re[c]) begin
        dout[c] <= mem[c][rp[c][7:0]];
        rp[c]   <= rp[c] + 1;
      end
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic [1:0] g;
    logic       perr;
    int         c;
  } cap_t;

  cap_t cap_q [$];
  int   onehot_viol, rd_viol, occ_viol, sr_cnt, perr_cnt, rds, acc_n;

  always @(negedge clock) begin
    int   nre;
    cap_t e;
    nre = int'(re[0]) + int'(re[1]) + int'(re[2]);
    if (nre > 1) onehot_viol++;
    for (int c = 0; c < 3; c++)
      if (re[c] && (grant_chan != 2'(c) || emp[c])) rd_viol++;
    if (|sr) sr_cnt++;
    if (parity_err) perr_cnt++;
    if (reset || (|sr)) begin
      rds = acc_n;
    end else begin
      rds += nre;
      if (out_valid && out_ready) acc_n++;
      if (rds - acc_n > 2) occ_viol++;
      if (out_valid && out_ready) begin
        e.d = out_data; e.last = out_last; e.g = grant_chan; e.perr = parity_err; e.c = cyc;
        cap_q.push_back(e);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int c, input logic [7:0] b);
    mem[c][wp[c][7:0]] = b;
    wp[c] = wp[c] + 1;
  endtask

  task automatic wait_caps(input int n, input int limit);
    int k = 0;
    while (cap_q.size() < n && k < limit) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (grant_chan !== 2'b11) begin errors++; $display("FAIL reset_grant: got %b want 11", grant_chan); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    checks++; if (re !== 3'b000) begin errors++; $display("FAIL reset_read_enb: got %b want 000", re); end
    checks++; if (sr !== 3'b000) begin errors++; $display("FAIL reset_soft_reset: got %b want 000", sr); end
    reset = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [7:0] exp [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    int b = cap_q.size();
    int gbad = 0;
    int k = 0;
    for (int i = 0; i < 5; i++) push(1, exp[i]);
    while (cap_q.size() < b + 5 && k < 40) begin
      step();
      k++;
      if (busy && grant_chan !== 2'd1) gbad++;
    end
    checks++;
    if (cap_q.size() < b + 5) begin
      errors++; $display("FAIL single_count: got %0d bytes want 5", cap_q.size() - b);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (cap_q[b+i].d !== exp[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, cap_q[b+i].d, exp[i]); end
        checks++; if (cap_q[b+i].last !== (i == 4)) begin errors++; $display("FAIL single_last%0d: got %b want %b", i, cap_q[b+i].last, (i == 4)); end
      end
      checks++; if (cap_q[b+4].c - cap_q[b].c !== 4) begin errors++; $display("FAIL single_consecutive: span %0d cycles want 4", cap_q[b+4].c - cap_q[b].c); end
    end
    checks++; if (gbad !== 0) begin errors++; $display("FAIL single_grant: %0d busy cycles with grant != 1, want 0", gbad); end
    checks++; if (busy !== 1'b1 || grant_chan !== 2'd1) begin errors++; $display("FAIL single_done_state: busy=%b grant=%b want 1/01", busy, grant_chan); end
    step();
    checks++; if (busy !== 1'b0 || grant_chan !== 2'b11) begin errors++; $display("FAIL single_idle: busy=%b grant=%b want 0/11", busy, grant_chan); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp  [12] = '{8'h08, 8'h01, 8'h02, 8'h0B, 8'h09, 8'h11, 8'h12, 8'h0A,
                              8'h0A, 8'h21, 8'h22, 8'h09};
    logic [7:0] exp2 [4]  = '{8'h08, 8'hAA, 8'hBB, 8'h19};
    int b;
    reset = 1'b1;
    step();
    reset = 1'b0;
    b = cap_q.size();
    for (int i = 0; i < 4; i++) push(0, exp[i]);
    for (int i = 4; i < 8; i++) push(1, exp[i]);
    for (int i = 8; i < 12; i++) push(2, exp[i]);
    wait_caps(b + 12, 100);
    checks++;
    if (cap_q.size() < b + 12) begin
      errors++; $display("FAIL rr_count: got %0d bytes want 12", cap_q.size() - b);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++; if (cap_q[b+i].d !== exp[i] || cap_q[b+i].g !== 2'(i / 4)) begin
          errors++; $display("FAIL rr_byte%0d: got %h on chan %0d want %h on chan %0d", i, cap_q[b+i].d, cap_q[b+i].g, exp[i], i / 4);
        end
      end
    end
    b = cap_q.size();
    for (int i = 0; i < 4; i++) push(0, exp2[i]);
    wait_caps(b + 4, 40);
    checks++;
    if (cap_q.size() < b + 4) begin
      errors++; $display("FAIL rr_refill_count: got %0d bytes want 4", cap_q.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (cap_q[b+i].d !== exp2[i] || cap_q[b+i].g !== 2'd0) begin
          errors++; $display("FAIL rr_refill%0d: got %h on chan %0d want %h on chan 0", i, cap_q[b+i].d, cap_q[b+i].g, exp2[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [6] = '{8'h10, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h10};
    int b = cap_q.size();
    int ov = occ_viol, oh = onehot_viol, rv = rd_viol, sc = sr_cnt;
    int k = 0;
    for (int i = 0; i < 6; i++) push(0, exp[i]);
    while (cap_q.size() < b + 6 && k < 80) begin
      step();
      out_ready = ~out_ready;
      k++;
    end
    out_ready = 1'b1;
    checks++;
    if (cap_q.size() != b + 6) begin
      errors++; $display("FAIL bp_count: got %0d bytes want 6", cap_q.size() - b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (cap_q[b+i].d !== exp[i] || cap_q[b+i].last !== (i == 5)) begin
          errors++; $display("FAIL bp_byte%0d: got %h last %b want %h last %b", i, cap_q[b+i].d, cap_q[b+i].last, exp[i], (i == 5));
        end
      end
    end
    checks++; if (occ_viol - ov !== 0) begin errors++; $display("FAIL bp_occupancy: %0d cycles above 2 entries, want 0", occ_viol - ov); end
    checks++; if (onehot_viol - oh !== 0 || rd_viol - rv !== 0) begin errors++; $display("FAIL bp_reads: onehot=%0d illegal=%0d want 0/0", onehot_viol - oh, rd_viol - rv); end
    checks++; if (sr_cnt - sc !== 0) begin errors++; $display("FAIL bp_no_abort: %0d soft resets want 0", sr_cnt - sc); end
  endtask

  task automatic test_timeout();
    logic [7:0] exp2 [3] = '{8'h04, 8'h77, 8'h73};
    int b = cap_q.size();
    int sc = sr_cnt;
    int n = 0;
    for (int i = 0; i < 3; i++) push(0, exp2[i]);
    push(2, 8'h22);
    for (int i = 1; i <= 8; i++) push(2, 8'(i));
    push(2, 8'h22);
    wait_caps(b + 3, 40);
    checks++;
    if (cap_q.size() < b + 3) begin
      errors++; $display("FAIL to_prefix_count: got %0d bytes want 3", cap_q.size() - b);
    end else begin
      checks++; if (cap_q[b].d !== 8'h22 || cap_q[b].g !== 2'd2 || cap_q[b+2].d !== 8'h02) begin
        errors++; $display("FAIL to_prefix: got %h/%h on chan %0d want 22/02 on chan 2", cap_q[b].d, cap_q[b+2].d, cap_q[b].g);
      end
    end
    out_ready = 1'b0;
    while (soft_reset_2 !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    checks++; if (n !== 30) begin errors++; $display("FAIL to_latency: soft_reset_2 after %0d cycles want 30", n); end
    checks++; if (out_valid !== 1'b0 || soft_reset_0 !== 1'b0 || soft_reset_1 !== 1'b0) begin
      errors++; $display("FAIL to_abort_outputs: out_valid=%b sr0=%b sr1=%b want 0/0/0", out_valid, soft_reset_0, soft_reset_1);
    end
    checks++; if (grant_chan !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL to_abort_state: grant=%b busy=%b want 10/1", grant_chan, busy); end
    step();
    out_ready = 1'b1;
    checks++; if (soft_reset_2 !== 1'b0) begin errors++; $display("FAIL to_pulse_width: soft_reset_2=%b want 0", soft_reset_2); end
    b = cap_q.size();
    wait_caps(b + 3, 40);
    checks++; if (sr_cnt - sc !== 1) begin errors++; $display("FAIL to_pulse_count: %0d soft reset cycles want 1", sr_cnt - sc); end
    checks++;
    if (cap_q.size() < b + 3) begin
      errors++; $display("FAIL to_next_count: got %0d bytes want 3", cap_q.size() - b);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (cap_q[b+i].d !== exp2[i] || cap_q[b+i].g !== 2'd0) begin
          errors++; $display("FAIL to_next%0d: got %h on chan %0d want %h on chan 0", i, cap_q[b+i].d, cap_q[b+i].g, exp2[i]);
        end
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] pk [6] = '{8'h05, 8'hA0, 8'h00, 8'h05, 8'hA0, 8'hA5};
    int b = cap_q.size();
    int pc = perr_cnt;
    logic exp_bad;
`ifdef PARITY_CHECK_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif
    for (int i = 0; i < 6; i++) push(1, pk[i]);
    wait_caps(b + 6, 60);
    checks++;
    if (cap_q.size() < b + 6) begin
      errors++; $display("FAIL par_count: got %0d bytes want 6", cap_q.size() - b);
    end else begin
      checks++; if (cap_q[b+2].perr !== exp_bad || cap_q[b+2].last !== 1'b1) begin
        errors++; $display("FAIL par_bad: parity_err=%b last=%b want %b/1", cap_q[b+2].perr, cap_q[b+2].last, exp_bad);
      end
      checks++; if (cap_q[b+5].perr !== 1'b0 || cap_q[b+5].d !== 8'hA5) begin
        errors++; $display("FAIL par_good: parity_err=%b byte=%h want 0/a5", cap_q[b+5].perr, cap_q[b+5].d);
      end
    end
    checks++; if (perr_cnt - pc !== int'(exp_bad)) begin errors++; $display("FAIL par_pulses: %0d pulses want %0d", perr_cnt - pc, exp_bad); end
  endtask

  task automatic test_reset_mid_packet();
    int b = cap_q.size();
    int sc = sr_cnt;
    push(0, 8'h28);
    for (int i = 0; i < 10; i++) push(0, 8'h40 + 8'(i));
    push(0, 8'h00);
    wait_caps(b + 2, 40);
    checks++; if (busy !== 1'b1 || grant_chan !== 2'd0) begin errors++; $display("FAIL rst_mid_pre: busy=%b grant=%b want 1/00", busy, grant_chan); end
    reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL rst_mid_egress: valid=%b last=%b data=%h want 0/0/00", out_valid, out_last, out_data);
    end
    checks++; if (grant_chan !== 2'b11 || busy !== 1'b0 || parity_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: grant=%b busy=%b perr=%b want 11/0/0", grant_chan, busy, parity_err);
    end
    checks++; if (re !== 3'b000 || sr !== 3'b000) begin errors++; $display("FAIL rst_mid_strobes: read_enb=%b soft_reset=%b want 000/000", re, sr); end
    step();
    checks++; if (sr_cnt - sc !== 0) begin errors++; $display("FAIL rst_mid_no_flush: %0d soft reset cycles want 0", sr_cnt - sc); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_parity();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
